tt_clk_sequencer: RTL and testbench

Run/halt/step controller for the clock and reset pins of the TinyTapeout DUT on the iCEBreaker board. It takes the board clock, holds the DUT in reset for a fixed delay, then generates a divided DUT clock. The clock is gated by run, single-step and cycle-limit controls. Its outputs feed bits 0 (clock) and 1 (reset) of the DUT input bus, in place of a free-running divider.

---
 rtl/tt_seq_pkg.sv | 22 ++
 rtl/tt_clk_div.sv | 33 +++
 rtl/tt_clk_sequencer.sv | 146 ++++++++++++++
 tb/tb_tt_clk_sequencer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_seq_pkg.sv
// Shared types and default sizes for the TinyTapeout clock/reset sequencer.
// Holds the controller state encoding and the parameter defaults used by the top.
package tt_seq_pkg;

  localparam int DEF_DIV_W     = 16;
  localparam int DEF_DELAY_BIT = 15;
  localparam int DEF_CYCLE_W   = 16;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_HOLD = 2'd0,
    ST_IDLE = 2'd1,
    ST_RUN  = 2'd2,
    ST_STEP = 2'd3
  } seq_state_t;

  function automatic logic seq_busy(input seq_state_t s);
    return s != ST_IDLE;
  endfunction

endpackage

// File: rtl/tt_clk_div.sv
// Half-period divider: strobes toggle once every div_value+1 enabled cycles.
// The period is latched on clear and at each toggle so mid-half changes wait their turn.
module tt_clk_div
  import tt_seq_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [DIV_W-1:0] div_value,
  output logic             toggle
);

  logic [DIV_W-1:0] count;
  logic [DIV_W-1:0] limit;

  assign toggle = enable && (count == limit);

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      count <= '0;
      limit <= '0;
    end else if (clear || toggle) begin
      count <= '0;
      limit <= div_value;
    end else if (enable) begin
      count <= count + DIV_W'(1);
    end
  end

endmodule

// File: rtl/tt_clk_sequencer.sv
// Run/halt/step controller driving the TinyTapeout DUT clock and reset pins.
// Define TT_SEQ_STEP_EN to build the single-step (STEP) state; otherwise step_req is ignored.
module tt_clk_sequencer
  import tt_seq_pkg::*;
#(
  parameter int DIV_W     = DEF_DIV_W,
  parameter int DELAY_BIT = DEF_DELAY_BIT,
  parameter int CYCLE_W   = DEF_CYCLE_W
) (
  input  logic               CLK,
  input  logic               rst,
  input  logic [DIV_W-1:0]   div_value,
  input  logic               run_req,
  input  logic               step_req,
  input  logic [CYCLE_W-1:0] stop_count,
  output logic               dut_clk,
  output logic               dut_rst,
  output logic               busy,
  output logic               limit_hit,
  output logic [CYCLE_W-1:0] cycle_count
);

  localparam int DLY_W = DELAY_BIT + 1;

  seq_state_t         state;
  seq_state_t         next_state;
  logic [DLY_W-1:0]   delay_cnt;
  logic [DLY_W-1:0]   delay_cnt_nxt;
  logic               dut_clk_nxt;
  logic               dut_rst_nxt;
  logic               busy_nxt;
  logic               limit_hit_nxt;
  logic [CYCLE_W-1:0] cycle_count_nxt;
  logic               run_prev;
  logic               run_rise;
  logic               tog;
  logic               clk_fall;
  logic               at_limit;
  logic               div_clear;
  logic               div_enable;

`ifndef TT_SEQ_STEP_EN
  logic unused_step_req;
  assign unused_step_req = step_req;
`endif

  assign run_rise   = run_req && !run_prev;
  assign clk_fall   = tog && dut_clk;
  assign at_limit   = (stop_count != '0) && (cycle_count == stop_count);
  assign div_enable = (state != ST_IDLE);

  tt_clk_div #(
    .DIV_W(DIV_W)
  ) u_div (
    .CLK      (CLK),
    .rst      (rst),
    .clear    (div_clear),
    .enable   (div_enable),
    .div_value(div_value),
    .toggle   (tog)
  );

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state       <= ST_HOLD;
      dut_clk     <= 1'b0;
      dut_rst     <= 1'b1;
      busy        <= 1'b1;
      limit_hit   <= 1'b0;
      cycle_count <= '0;
      delay_cnt   <= '0;
      run_prev    <= 1'b0;
    end else begin
      state       <= next_state;
      dut_clk     <= dut_clk_nxt;
      dut_rst     <= dut_rst_nxt;
      busy        <= busy_nxt;
      limit_hit   <= limit_hit_nxt;
      cycle_count <= cycle_count_nxt;
      delay_cnt   <= delay_cnt_nxt;
      run_prev    <= run_req;
    end
  end

  // RUN and STEP only ever leave on a falling toggle, so the high half is never cut.
  always_comb begin
    next_state = state;
    case (state)
      ST_HOLD: begin
        if (delay_cnt[DELAY_BIT] && !dut_clk) next_state = ST_IDLE;
      end
      ST_IDLE: begin
        if (run_rise) next_state = ST_RUN;
`ifdef TT_SEQ_STEP_EN
        else if (step_req) next_state = ST_STEP;
`endif
      end
      ST_RUN: begin
        if (clk_fall && (!run_req || at_limit)) next_state = ST_IDLE;
      end
`ifdef TT_SEQ_STEP_EN
      ST_STEP: begin
        if (clk_fall) next_state = ST_IDLE;
      end
`endif
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    dut_clk_nxt   = dut_clk;
    delay_cnt_nxt = delay_cnt;
    limit_hit_nxt = limit_hit;
    div_clear     = 1'b0;
    dut_rst_nxt   = (next_state == ST_HOLD);
    busy_nxt      = seq_busy(next_state);
    case (state)
      ST_HOLD: begin
        if (next_state == ST_IDLE) begin
          dut_clk_nxt = 1'b0;
          div_clear   = 1'b1;
        end else begin
          if (tog) dut_clk_nxt = !dut_clk;
          if (!delay_cnt[DELAY_BIT]) delay_cnt_nxt = delay_cnt + DLY_W'(1);
        end
      end
      ST_IDLE: begin
        dut_clk_nxt = 1'b0;
        if (next_state != ST_IDLE) div_clear = 1'b1;
        if (next_state == ST_RUN) limit_hit_nxt = 1'b0;
      end
      ST_RUN: begin
        if (tog) dut_clk_nxt = !dut_clk;
        if (next_state == ST_IDLE && at_limit) limit_hit_nxt = 1'b1;
      end
`ifdef TT_SEQ_STEP_EN
      ST_STEP: begin
        if (tog) dut_clk_nxt = !dut_clk;
      end
`endif
      default: dut_clk_nxt = 1'b0;
    endcase
    cycle_count_nxt = (dut_clk_nxt && !dut_clk) ? cycle_count + CYCLE_W'(1) : cycle_count;
  end

endmodule

// File: tb/tb_tt_clk_sequencer.sv
// Scoreboard bench for tt_clk_sequencer: a timing model predicts every dut_clk edge.
// A negedge monitor pops and compares; define TT_SEQ_STEP_EN to exercise single-step.
module tb_tt_clk_sequencer;

  localparam int DIV_W     = 4;
  localparam int DELAY_BIT = 3;
  localparam int CYCLE_W   = 8;
  localparam int HOLD_LEN  = 1 << DELAY_BIT;
  localparam int CNT_MOD   = 1 << CYCLE_W;

  logic               CLK = 1'b0;
  logic               rst = 1'b0;
  logic [DIV_W-1:0]   div_value = '0;
  logic               run_req = 1'b0;
  logic               step_req = 1'b0;
  logic [CYCLE_W-1:0] stop_count = '0;
  logic               dut_clk;
  logic               dut_rst;
  logic               busy;
  logic               limit_hit;
  logic [CYCLE_W-1:0] cycle_count;

  typedef struct {
    int at;
    int level;
    int cnt;
  } clk_event_t;

  clk_event_t exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         cc_model = 0;
  bit         mon_en = 1'b0;
  logic       prev_clk = 1'b0;

  tt_clk_sequencer #(
    .DIV_W    (DIV_W),
    .DELAY_BIT(DELAY_BIT),
    .CYCLE_W  (CYCLE_W)
  ) dut (
    .CLK        (CLK),
    .rst        (rst),
    .div_value  (div_value),
    .run_req    (run_req),
    .step_req   (step_req),
    .stop_count (stop_count),
    .dut_clk    (dut_clk),
    .dut_rst    (dut_rst),
    .busy       (busy),
    .limit_hit  (limit_hit),
    .cycle_count(cycle_count)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc++;

  // Every observed dut_clk edge must match the oldest predicted edge in time, direction and count.
  always @(negedge CLK) begin : monitor
    clk_event_t e;
    if (!mon_en || rst) begin
      prev_clk = dut_clk;
    end else if (dut_clk !== prev_clk) begin
      prev_clk = dut_clk;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL edge_unexpected: got level %0d at cycle %0d count %0d, required no edge",
                 dut_clk, cyc, cycle_count);
      end else begin
        e = exp_q.pop_front();
        if (e.at != cyc || e.level != int'(dut_clk) || e.cnt != int'(cycle_count)) begin
          errors++;
          $display("[TB] FAIL edge: got cycle %0d level %0d count %0d, required cycle %0d level %0d count %0d",
                   cyc, dut_clk, cycle_count, e.at, e.level, e.cnt);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic waitCycle(input int target);
    while (cyc < target) @(negedge CLK);
  endtask

  task automatic pushEdge(input int at, input int level, input int cnt);
    clk_event_t e;
    e.at = at;
    e.level = level;
    e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  // Run model: rises at t0+h*(2k+1), falls at t0+h*(2k+2); stop at the first fall
  // that reaches the limit or that samples run_req low.
  task automatic planRun(input int n, input int d, input int m, input int sc,
                         output int stop, output bit hit);
    int t0;
    int h;
    t0 = n + 1;
    h = d + 1;
    hit = 1'b0;
    stop = t0;
    for (int k = 0; k < 300; k++) begin
      cc_model = (cc_model + 1) % CNT_MOD;
      pushEdge(t0 + h * (2 * k + 1), 1, cc_model);
      stop = t0 + h * (2 * k + 2);
      pushEdge(stop, 0, cc_model);
      if (sc != 0 && cc_model == sc) begin
        hit = 1'b1;
        break;
      end
      if (stop > m) break;
    end
  endtask

  task automatic applyReset();
    int r;
    int e;
    logic clk_m;
    rst = 1'b1;
    run_req = 1'b0;
    step_req = 1'b0;
    div_value = '0;
    stop_count = '0;
    #1;
    checkOutput("rst_dut_clk", int'(dut_clk), 0);
    checkOutput("rst_dut_rst", int'(dut_rst), 1);
    checkOutput("rst_cycle_count", int'(cycle_count), 0);
    checkOutput("rst_busy", int'(busy), 1);
    checkOutput("rst_limit_hit", int'(limit_hit), 0);
    exp_q.delete();
    cc_model = 0;
    repeat (2) @(negedge CLK);
    rst = 1'b0;
    mon_en = 1'b1;
    r = cyc;
    clk_m = 1'b0;
    for (e = 1; e < 100; e++) begin
      if (e - 1 >= HOLD_LEN && clk_m == 1'b0) break;
      clk_m = !clk_m;
      if (clk_m) cc_model++;
      pushEdge(r + e, int'(clk_m), cc_model);
    end
    waitCycle(r + e - 1);
    checkOutput("hold_dut_rst_high", int'(dut_rst), 1);
    waitCycle(r + e);
    checkOutput("hold_exit_dut_rst", int'(dut_rst), 0);
    checkOutput("hold_exit_dut_clk", int'(dut_clk), 0);
    checkOutput("hold_exit_busy", int'(busy), 0);
    waitCycle(r + e + 4);
    checkOutput("hold_idle_dut_clk", int'(dut_clk), 0);
    checkOutput("hold_queue_drained", exp_q.size(), 0);
  endtask

  task automatic applyStimulus(input int d, input int sc, input int drop_after, input bit with_step);
    int n;
    int m;
    int stop;
    bit hit;
    div_value = DIV_W'(d);
    stop_count = CYCLE_W'(sc);
    run_req = 1'b0;
    step_req = 1'b0;
    @(negedge CLK);
    n = cyc;
    run_req = 1'b1;
    step_req = with_step;
    m = (drop_after < 0) ? 32'h3fffffff : n + drop_after;
    planRun(n, d, m, sc, stop, hit);
    @(negedge CLK);
    step_req = 1'b0;
    checkOutput("run_busy", int'(busy), 1);
    checkOutput("run_limit_cleared", int'(limit_hit), 0);
    if (drop_after >= 0 && m < stop) begin
      waitCycle(m);
      run_req = 1'b0;
    end
    waitCycle(stop);
    checkOutput("run_stop_busy", int'(busy), 0);
    checkOutput("run_stop_dut_clk", int'(dut_clk), 0);
    checkOutput("run_stop_limit_hit", int'(limit_hit), int'(hit));
    checkOutput("run_stop_cycle_count", int'(cycle_count), cc_model);
    waitCycle(stop + 2 * (d + 1) + 6);
    checkOutput("run_after_busy", int'(busy), 0);
    checkOutput("run_queue_drained", exp_q.size(), 0);
    run_req = 1'b0;
  endtask

  task automatic stepScenario(input int d, input bit second_pulse);
    int n;
    int h;
    div_value = DIV_W'(d);
    h = d + 1;
    @(negedge CLK);
    n = cyc;
    step_req = 1'b1;
`ifdef TT_SEQ_STEP_EN
    cc_model = (cc_model + 1) % CNT_MOD;
    pushEdge(n + 1 + h, 1, cc_model);
    pushEdge(n + 1 + 2 * h, 0, cc_model);
`endif
    @(negedge CLK);
    step_req = 1'b0;
`ifdef TT_SEQ_STEP_EN
    checkOutput("step_busy", int'(busy), 1);
`else
    checkOutput("step_disabled_busy", int'(busy), 0);
`endif
    if (second_pulse) begin
      @(negedge CLK);
      step_req = 1'b1;
      @(negedge CLK);
      step_req = 1'b0;
    end
    waitCycle(n + 1 + 2 * h);
    checkOutput("step_done_busy", int'(busy), 0);
    checkOutput("step_done_dut_clk", int'(dut_clk), 0);
    checkOutput("step_cycle_count", int'(cycle_count), cc_model);
    waitCycle(n + 1 + 4 * h + 2);
    checkOutput("step_queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int stop;
    bit hit;
    int sc;
    int n;
    @(negedge CLK);
    applyReset();

    applyStimulus(2, 0, 22, 1'b0);

    sc = (cc_model + 5) % CNT_MOD;
    if (sc == 0) sc = 1;
    applyStimulus(0, sc, -1, 1'b0);

    for (int i = 0; i < 3; i++) stepScenario(1, i == 1);

    applyStimulus(1, 0, 14, 1'b1);

    for (int i = 0; i < 10; i++) begin
      case ($urandom_range(0, 2))
        0: applyStimulus($urandom_range(0, 3), (cc_model + $urandom_range(1, 4)) % CNT_MOD,
                         $urandom_range(2, 30), 1'b0);
        1: stepScenario($urandom_range(0, 3), 1'(($urandom_range(0, 1))));
        default: applyStimulus($urandom_range(0, 3), 0, $urandom_range(2, 30), 1'(($urandom_range(0, 1))));
      endcase
    end

    div_value = DIV_W'(1);
    stop_count = '0;
    @(negedge CLK);
    n = cyc;
    run_req = 1'b1;
    planRun(n, 1, 32'h3fffffff, 0, stop, hit);
    for (int i = 0; i < 40 && dut_clk !== 1'b1; i++) @(negedge CLK);
    checkOutput("abort_dut_clk_high", int'(dut_clk), 1);
    #2;
    applyReset();

    applyStimulus(0, 0, 8, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
